// File: rtl/bsg_scan_frame_carry_if.sv
// Handshake bundle for bsg_scan_frame_carry: valid/ready input side, valid/yumi output side.
// The slave modport is the block's view, the master modport is the producer/consumer view.
interface bsg_scan_frame_carry_if #(
   parameter int width_p       = 16,
   parameter int count_width_p = 8
);
   logic                     v_i;
   logic [width_p-1:0]       data_i;
   logic                     last_i;
   logic                     ready_o;
   logic                     v_o;
   logic [width_p-1:0]       data_o;
   logic                     last_o;
   logic [count_width_p-1:0] idx_o;
   logic                     err_o;
   logic                     yumi_i;

   modport slave (
      input  v_i, data_i, last_i, yumi_i,
      output ready_o, v_o, data_o, last_o, idx_o, err_o
   );

   modport master (
      output v_i, data_i, last_i, yumi_i,
      input  ready_o, v_o, data_o, last_o, idx_o, err_o
   );
endinterface

// File: rtl/bsg_scan_frame_carry.sv
// Extends a per-word XOR suffix scan across a multi-word frame (MSW first) by folding in
// the parity of all earlier words of the frame; one registered valid/yumi output stage.
module bsg_scan_frame_carry #(
   parameter int width_p       = 16,
   parameter int count_width_p = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   bsg_scan_frame_carry_if.slave bus
);
   localparam logic [count_width_p-1:0] cnt_max_lp = {count_width_p{1'b1}};
   localparam logic [count_width_p-1:0] cnt_one_lp = {{(count_width_p-1){1'b0}}, 1'b1};

   logic                     v_q, v_d;
   logic [width_p-1:0]       data_q, data_d;
   logic                     last_q, last_d;
   logic [count_width_p-1:0] idx_q, idx_d;
   logic                     err_q, err_d;
   logic                     carry_q, carry_d;
   logic [count_width_p-1:0] cnt_q, cnt_d;
   logic                     sat_q, sat_d;
   logic                     ready_s;
   logic                     accept_s;

   assign ready_s  = ~v_q | bus.yumi_i;
   assign accept_s = bus.v_i & ready_s;

   // sat_q marks that the frame already holds 2^count_width_p words, so any further word overflows
   always_comb begin
      v_d     = v_q;
      data_d  = data_q;
      last_d  = last_q;
      idx_d   = idx_q;
      err_d   = err_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      if (accept_s) begin
         v_d    = 1'b1;
         data_d = bus.data_i ^ {width_p{carry_q}};
         last_d = bus.last_i;
         idx_d  = cnt_q;
         err_d  = err_q | sat_q;
         if (bus.last_i) begin
            carry_d = 1'b0;
            cnt_d   = {count_width_p{1'b0}};
            sat_d   = 1'b0;
         end else begin
            carry_d = carry_q ^ bus.data_i[0];
            if (cnt_q == cnt_max_lp) begin
               cnt_d = cnt_q;
               sat_d = 1'b1;
            end else begin
               cnt_d = cnt_q + cnt_one_lp;
               sat_d = sat_q;
            end
         end
      end else if (bus.yumi_i) begin
         v_d = 1'b0;
      end else begin
         v_d = v_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         v_q     <= 1'b0;
         data_q  <= {width_p{1'b0}};
         last_q  <= 1'b0;
         idx_q   <= {count_width_p{1'b0}};
         err_q   <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= {count_width_p{1'b0}};
         sat_q   <= 1'b0;
      end else begin
         v_q     <= v_d;
         data_q  <= data_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   assign bus.ready_o = ready_s;
   assign bus.v_o     = v_q;
   assign bus.data_o  = data_q;
   assign bus.last_o  = last_q;
   assign bus.idx_o   = idx_q;
   assign bus.err_o   = err_q;
endmodule

// File: tb/tb_bsg_scan_frame_carry.sv
// Self-checking bench for bsg_scan_frame_carry: directed vectors, overflow on a 2-bit counter
// instance, mid-frame reset, and random streams against a whole-frame suffix-XOR model.
module tb_bsg_scan_frame_carry;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   bsg_scan_frame_carry_if #(.width_p(16), .count_width_p(8)) bus1 ();
   bsg_scan_frame_carry_if #(.width_p(16), .count_width_p(2)) bus2 ();

   bsg_scan_frame_carry #(.width_p(16), .count_width_p(8)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .bus(bus1)
   );
   bsg_scan_frame_carry #(.width_p(16), .count_width_p(2)) dut_ovf (
      .clk_i(clk), .reset_n_i(reset_n), .bus(bus2)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] din;
      logic        lin;
      logic [15:0] dexp;
      logic [7:0]  iexp;
      logic        lexp;
   } vec_t;

   typedef struct {
      logic [15:0] data;
      logic        last;
      logic [7:0]  idx;
      logic        err;
   } exp_t;

   vec_t        vecs[3];
   exp_t        expq[$];
   logic [15:0] frame_raw[$];
   logic        model_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output of the upstream per-word scan stage: bit k = XOR of raw bits k..15
   function automatic logic [15:0] scan16(input logic [15:0] w);
      logic [15:0] s;
      for (int k = 0; k < 16; k++) s[k] = ^(w >> k);
      return s;
   endfunction

   // Bit k of word j = XOR of every frame bit at or above it (all earlier words, then bits k..15)
   function automatic logic [15:0] ref_out(input int j);
      logic [15:0] r;
      logic        acc;
      for (int k = 0; k < 16; k++) begin
         acc = 1'b0;
         for (int i = 0; i <= j; i++)
            for (int b = 0; b < 16; b++)
               if (i < j || b >= k) acc ^= frame_raw[i][b];
         r[k] = acc;
      end
      return r;
   endfunction

   task automatic consume_check();
      exp_t e;
      if (bus1.v_o && bus1.yumi_i) begin
         chk("rand_pending", 32'(expq.size() > 0), 32'd1);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("rand_data", 32'(bus1.data_o), 32'(e.data));
            chk("rand_last", 32'(bus1.last_o), 32'(e.last));
            chk("rand_idx", 32'(bus1.idx_o), 32'(e.idx));
            chk("rand_err", 32'(bus1.err_o), 32'(e.err));
         end
      end
   endtask

   initial begin
      logic [15:0] bp_in[4];
      logic [15:0] bp_exp[4];
      logic [1:0]  ovf_idx[5];
      int          pos;
      int          flen;
      exp_t        e;

      vecs[0] = '{din: 16'h0001, lin: 1'b0, dexp: 16'h0001, iexp: 8'd0, lexp: 1'b0};
      vecs[1] = '{din: 16'h00F0, lin: 1'b1, dexp: 16'hFF0F, iexp: 8'd1, lexp: 1'b1};
      vecs[2] = '{din: 16'h0003, lin: 1'b1, dexp: 16'h0003, iexp: 8'd0, lexp: 1'b1};
      bp_in  = '{16'h0005, 16'h0102, 16'h0007, 16'h0080};
      bp_exp = '{16'h0005, 16'hFEFD, 16'hFFF8, 16'h0080};
      ovf_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};

      reset_n = 1'b0;
      bus1.v_i = 1'b0; bus1.data_i = 16'h0000; bus1.last_i = 1'b0; bus1.yumi_i = 1'b0;
      bus2.v_i = 1'b0; bus2.data_i = 16'h0000; bus2.last_i = 1'b0; bus2.yumi_i = 1'b0;
      repeat (2) tick();
      chk("rst_v", 32'(bus1.v_o), 32'd0);
      chk("rst_data", 32'(bus1.data_o), 32'd0);
      chk("rst_last", 32'(bus1.last_o), 32'd0);
      chk("rst_idx", 32'(bus1.idx_o), 32'd0);
      chk("rst_err", 32'(bus1.err_o), 32'd0);
      chk("rst_ready", 32'(bus1.ready_o), 32'd1);
      reset_n = 1'b1;
      tick();

      // Two-word frame followed by a single-word frame, full throughput
      for (int i = 0; i < 3; i++) begin
         bus1.v_i = 1'b1; bus1.data_i = vecs[i].din; bus1.last_i = vecs[i].lin;
         bus1.yumi_i = bus1.v_o;
         tick();
         chk("vec_v", 32'(bus1.v_o), 32'd1);
         chk("vec_data", 32'(bus1.data_o), 32'(vecs[i].dexp));
         chk("vec_idx", 32'(bus1.idx_o), 32'(vecs[i].iexp));
         chk("vec_last", 32'(bus1.last_o), 32'(vecs[i].lexp));
      end
      bus1.v_i = 1'b0; bus1.yumi_i = bus1.v_o;
      tick();
      chk("vec_drain_v", 32'(bus1.v_o), 32'd0);
      bus1.yumi_i = 1'b0;

      // Backpressure: output held for 5 cycles, then the frame streams out in order
      bus1.v_i = 1'b1; bus1.data_i = bp_in[0]; bus1.last_i = 1'b0; bus1.yumi_i = 1'b0;
      tick();
      chk("bp_first", 32'(bus1.data_o), 32'(bp_exp[0]));
      for (int c = 0; c < 5; c++) begin
         bus1.v_i = 1'b1; bus1.data_i = bp_in[1]; bus1.last_i = 1'b0; bus1.yumi_i = 1'b0;
         tick();
         chk("bp_ready", 32'(bus1.ready_o), 32'd0);
         chk("bp_hold", 32'(bus1.data_o), 32'(bp_exp[0]));
         chk("bp_hold_idx", 32'(bus1.idx_o), 32'd0);
      end
      for (int k = 1; k < 4; k++) begin
         bus1.v_i = 1'b1; bus1.data_i = bp_in[k]; bus1.last_i = (k == 3); bus1.yumi_i = 1'b1;
         tick();
         chk("bp_data", 32'(bus1.data_o), 32'(bp_exp[k]));
         chk("bp_idx", 32'(bus1.idx_o), 32'(k));
      end
      bus1.v_i = 1'b0; bus1.yumi_i = 1'b1;
      tick();
      chk("bp_drain_v", 32'(bus1.v_o), 32'd0);
      bus1.yumi_i = 1'b0;

      // Overflow on the 2-bit counter instance
      for (int i = 0; i < 5; i++) begin
         bus2.v_i = 1'b1; bus2.data_i = 16'(i + 1); bus2.last_i = 1'b0; bus2.yumi_i = bus2.v_o;
         tick();
         chk("ovf_idx", 32'(bus2.idx_o), 32'(ovf_idx[i]));
         chk("ovf_err", 32'(bus2.err_o), 32'(i == 4));
      end
      bus2.v_i = 1'b1; bus2.data_i = 16'h0006; bus2.last_i = 1'b1; bus2.yumi_i = bus2.v_o;
      tick();
      chk("ovf_last_idx", 32'(bus2.idx_o), 32'd3);
      chk("ovf_last_err", 32'(bus2.err_o), 32'd1);
      bus2.v_i = 1'b1; bus2.data_i = 16'h0001; bus2.last_i = 1'b1; bus2.yumi_i = bus2.v_o;
      tick();
      chk("ovf_next_idx", 32'(bus2.idx_o), 32'd0);
      chk("ovf_sticky", 32'(bus2.err_o), 32'd1);
      bus2.v_i = 1'b0; bus2.yumi_i = bus2.v_o;
      tick();
      bus2.yumi_i = 1'b0;

      // Reset in mid-frame discards carry and count
      bus1.v_i = 1'b1; bus1.data_i = 16'h8001; bus1.last_i = 1'b0; bus1.yumi_i = 1'b0;
      tick();
      chk("mid_v", 32'(bus1.v_o), 32'd1);
      bus1.v_i = 1'b0; reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("mid_rst_v", 32'(bus1.v_o), 32'd0);
      chk("mid_rst_err", 32'(bus1.err_o), 32'd0);
      chk("mid_rst_err_ovf", 32'(bus2.err_o), 32'd0);
      bus1.v_i = 1'b1; bus1.data_i = 16'h0010; bus1.last_i = 1'b1;
      tick();
      chk("mid_data", 32'(bus1.data_o), 32'h0010);
      chk("mid_idx", 32'(bus1.idx_o), 32'd0);
      bus1.v_i = 1'b0; bus1.yumi_i = 1'b1;
      tick();
      bus1.yumi_i = 1'b0;

      // Random frames with random valid and yumi
      pos = 0; flen = 0; model_err = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (pos == flen) begin
            flen = $urandom_range(1, 20);
            frame_raw.delete();
            for (int i = 0; i < flen; i++) frame_raw.push_back(16'($urandom));
            pos = 0;
         end
         bus1.v_i    = ($urandom_range(0, 3) != 0);
         bus1.data_i = scan16(frame_raw[pos]);
         bus1.last_i = (pos == flen - 1);
         bus1.yumi_i = bus1.v_o & ($urandom_range(0, 3) != 0);
         @(negedge clk);
         consume_check();
         if (bus1.v_i && bus1.ready_o) begin
            if (pos >= 256) model_err = 1'b1;
            e.data = ref_out(pos);
            e.last = (pos == flen - 1);
            e.idx  = (pos > 255) ? 8'd255 : 8'(pos);
            e.err  = model_err;
            expq.push_back(e);
            pos++;
         end
         tick();
      end
      for (int c = 0; c < 5; c++) begin
         bus1.v_i = 1'b0;
         bus1.yumi_i = bus1.v_o;
         @(negedge clk);
         consume_check();
         tick();
      end
      chk("rand_drained", 32'(expq.size()), 32'd0);
      chk("rand_final_v", 32'(bus1.v_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
